// File: rtl/multicycle_controller_pkg.sv
// Shared control encodings for the RV32I datapath, plus the multi-cycle sequencer's
// state type and datapath select values.
package multicycle_controller_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_op;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } Imm_ex_op;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op;

    // What the ALU is being used for; the decoder turns this plus funct fields into alu_op.
    typedef enum logic [1:0] {
        ALU_CLS_ADD = 2'd0,
        ALU_CLS_SUB = 2'd1,
        ALU_CLS_R   = 2'd2,
        ALU_CLS_I   = 2'd3
    } alu_class_t;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC_R  = 4'd2,
        ST_EXEC_I  = 4'd3,
        ST_MEM_ADR = 4'd4,
        ST_MEM_RD  = 4'd5,
        ST_MEM_WB  = 4'd6,
        ST_MEM_WR  = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_ALU_WB  = 4'd9,
        ST_TRAP    = 4'd10
    } mc_state_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic TRAP_ILLEGAL     = 1'b0;
    localparam logic TRAP_MEM_TIMEOUT = 1'b1;

    // Immediate format is a pure function of the opcode; unknown opcodes fall back to I.
    function automatic Imm_ex_op imm_format(input logic [6:0] opc);
        case (opc)
            OPC_STORE:          return IMM_S;
            OPC_BRANCH:         return IMM_B;
            OPC_LUI, OPC_AUIPC: return IMM_U;
            OPC_JAL:            return IMM_J;
            default:            return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: instruction class plus funct3/funct7_5 select the ALU operation.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    input  alu_class_t alu_class_i,
    output alu_op      alu_ctrl_o
);

    logic alt_op;

    // Immediate ops only have an alternate form for shifts (srai); addi never subtracts.
    assign alt_op = funct7_5_i && ((alu_class_i == ALU_CLS_R) || (funct3_i == 3'b101));

    always_comb begin
        // NOTE: default first so every path assigns alu_ctrl_o and no latch is inferred.
        alu_ctrl_o = ALU_ADD;
        case (alu_class_i)
            ALU_CLS_ADD: alu_ctrl_o = ALU_ADD;
            ALU_CLS_SUB: alu_ctrl_o = ALU_SUB;
            ALU_CLS_R, ALU_CLS_I: begin
                case (funct3_i)
                    3'b000:  alu_ctrl_o = alt_op ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl_o = ALU_SLL;
                    3'b010:  alu_ctrl_o = ALU_SLT;
                    3'b011:  alu_ctrl_o = ALU_SLTU;
                    3'b100:  alu_ctrl_o = ALU_XOR;
                    3'b101:  alu_ctrl_o = alt_op ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl_o = ALU_OR;
                    default: alu_ctrl_o = ALU_AND;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: steps the shared ALU, register file and memory port through
// FETCH/DECODE/EXEC/MEM/WB, trapping on illegal opcodes or memory timeouts.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       neg,
    input  logic       mem_ready,
    output logic       mem_req,
    output mem_op      mem_rdwr,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       regwrite,
    output Imm_ex_op   imm_src,
    output alu_op      alu_ctrl,
    output logic       retire,
    output logic       trap,
    output logic       trap_cause
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    mc_state_t  state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic       cause_q, cause_d;

    logic       in_mem_state;
    logic       timeout;
    logic       br_valid;
    logic       br_taken;
    alu_class_t alu_class;

    assign in_mem_state = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

    // wait_q holds the not-ready cycles already spent; this cycle would be number MEM_TIMEOUT.
    assign timeout = in_mem_state && !mem_ready && (wait_q >= CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        br_valid = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = neg;
            3'b101:  br_taken = !neg;
            default: br_valid = 1'b0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .funct3_i    (funct3),
        .funct7_5_i  (funct7_5),
        .alu_class_i (alu_class),
        .alu_ctrl_o  (alu_ctrl)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
            cause_q <= TRAP_ILLEGAL;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_MEM_TIMEOUT;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OPC_R:               state_d = ST_EXEC_R;
                    OPC_I:               state_d = ST_EXEC_I;
                    OPC_LOAD, OPC_STORE: state_d = ST_MEM_ADR;
                    OPC_BRANCH:          state_d = ST_BRANCH;
                    default: begin
                        state_d = ST_TRAP;
                        cause_d = TRAP_ILLEGAL;
                    end
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: state_d = ST_ALU_WB;
            ST_ALU_WB:            state_d = ST_FETCH;
            ST_MEM_ADR:           state_d = (opcode == OPC_STORE) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready) begin
                    state_d = ST_MEM_WB;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_MEM_TIMEOUT;
                end
            end
            ST_MEM_WB: state_d = ST_FETCH;
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_MEM_TIMEOUT;
                end
            end
            ST_BRANCH: begin
                if (br_valid) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Staying in a request state only happens while waiting; any transition restarts the count.
    assign wait_d = (in_mem_state && (state_d == state_q)) ? wait_q + CNT_W'(1) : '0;

    always_comb begin
        mem_req    = 1'b0;
        mem_rdwr   = MEM_IDLE;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        result_src = RES_ALU_OUT;
        regwrite   = 1'b0;
        alu_class  = ALU_CLS_ADD;
        retire     = 1'b0;
        trap       = 1'b0;
        trap_cause = 1'b0;
        imm_src    = IMM_I;
        if (!rst) begin
            imm_src = imm_format(opcode);
            case (state_q)
                ST_FETCH: begin
                    mem_req    = 1'b1;
                    mem_rdwr   = MEM_READ;
                    alu_src_a  = SRC_A_PC;
                    alu_src_b  = SRC_B_FOUR;
                    result_src = RES_ALU;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                ST_DECODE: begin
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_IMM;
                end
                ST_EXEC_R: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                    alu_class = ALU_CLS_R;
                end
                ST_EXEC_I: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    alu_class = ALU_CLS_I;
                end
                ST_ALU_WB: begin
                    result_src = RES_ALU_OUT;
                    regwrite   = 1'b1;
                    retire     = 1'b1;
                end
                ST_MEM_ADR: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                end
                ST_MEM_RD: begin
                    mem_req  = 1'b1;
                    mem_rdwr = MEM_READ;
                    adr_src  = 1'b1;
                end
                ST_MEM_WB: begin
                    result_src = RES_MEM;
                    regwrite   = 1'b1;
                    retire     = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_req  = 1'b1;
                    mem_rdwr = MEM_WRITE;
                    adr_src  = 1'b1;
                    retire   = mem_ready;
                end
                ST_BRANCH: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_RS2;
                    alu_class  = ALU_CLS_SUB;
                    result_src = RES_ALU_OUT;
                    pc_write   = br_valid && br_taken;
                    retire     = br_valid;
                end
                ST_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle scoreboard bench: each scenario queues expected output vectors (with a care
// mask) alongside the inputs for that cycle, then drains the queue against the DUT.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic [1:0] rdwr;
        logic       pc_write;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] rs;
        logic       regwrite;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       retire;
        logic       trap;
        logic       cause;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        z;
        logic        n;
        logic [31:0] instr;
        exp_t        val;
        exp_t        care;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       neg = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req;
    mem_op      mem_rdwr;
    logic       pc_write, ir_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic       regwrite;
    Imm_ex_op   imm_src;
    alu_op      alu_ctrl;
    logic       retire, trap, trap_cause;

    int errors = 0;
    int checks = 0;
    sb_t sb_q[$];
    logic [31:0] cur_instr = '0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .zero       (zero),
        .neg        (neg),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_rdwr   (mem_rdwr),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .regwrite   (regwrite),
        .imm_src    (imm_src),
        .alu_ctrl   (alu_ctrl),
        .retire     (retire),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    function automatic logic [2:0] exp_imm(input logic [31:0] ins);
        case (ins[6:0])
            7'h23:   return 3'(IMM_S);
            7'h63:   return 3'(IMM_B);
            default: return 3'(IMM_I);
        endcase
    endfunction

    // Strobes, request, rdwr and trap are always checked; other fields only where meaningful.
    function automatic sb_t base(input logic rdy);
        sb_t s;
        s.rst = 1'b0; s.rdy = rdy; s.z = 1'b0; s.n = 1'b0; s.instr = cur_instr;
        s.val = '0; s.care = '0;
        s.care.mem_req = 1'b1; s.care.rdwr = 2'b11; s.care.pc_write = 1'b1;
        s.care.ir_write = 1'b1; s.care.regwrite = 1'b1; s.care.retire = 1'b1; s.care.trap = 1'b1;
        return s;
    endfunction

    function automatic sb_t in_reset(input logic rdy);
        sb_t s = base(rdy);
        s.rst = 1'b1; s.care = '1;
        return s;
    endfunction

    function automatic sb_t fetch(input logic rdy);
        sb_t s = base(rdy);
        s.val.mem_req = 1'b1; s.val.rdwr = MEM_READ;
        s.val.ir_write = rdy; s.val.pc_write = rdy;
        s.care.adr_src = 1'b1; s.care.a = 2'b11; s.care.b = 2'b11; s.care.alu = 4'hF; s.care.rs = 2'b11;
        s.val.adr_src = 1'b0; s.val.a = 2'b00; s.val.b = 2'b10; s.val.alu = ALU_ADD; s.val.rs = 2'b10;
        return s;
    endfunction

    function automatic sb_t decode();
        sb_t s = base(1'b1);
        s.care.a = 2'b11; s.care.b = 2'b11; s.care.alu = 4'hF; s.care.imm = 3'b111;
        s.val.a = 2'b01; s.val.b = 2'b01; s.val.alu = ALU_ADD; s.val.imm = exp_imm(cur_instr);
        return s;
    endfunction

    function automatic sb_t exec_op(input logic [1:0] b, input alu_op op);
        sb_t s = base(1'b1);
        s.care.a = 2'b11; s.care.b = 2'b11; s.care.alu = 4'hF;
        s.val.a = 2'b10; s.val.b = b; s.val.alu = op;
        if (b == 2'b01) begin
            s.care.imm = 3'b111; s.val.imm = exp_imm(cur_instr);
        end
        return s;
    endfunction

    function automatic sb_t writeback(input logic [1:0] rs);
        sb_t s = base(1'b1);
        s.care.rs = 2'b11; s.val.rs = rs; s.val.regwrite = 1'b1; s.val.retire = 1'b1;
        return s;
    endfunction

    function automatic sb_t mem_access(input logic rdy, input logic wr);
        sb_t s = base(rdy);
        s.val.mem_req = 1'b1; s.val.rdwr = wr ? MEM_WRITE : MEM_READ;
        s.care.adr_src = 1'b1; s.val.adr_src = 1'b1;
        s.val.retire = wr & rdy;
        return s;
    endfunction

    function automatic sb_t branch(input logic z, input logic n, input logic pcw, input logic ret);
        sb_t s = base(1'b1);
        s.z = z; s.n = n;
        s.care.a = 2'b11; s.care.b = 2'b11; s.care.alu = 4'hF; s.care.rs = 2'b11;
        s.val.a = 2'b10; s.val.b = 2'b00; s.val.alu = ALU_SUB; s.val.rs = 2'b00;
        s.val.pc_write = pcw; s.val.retire = ret;
        return s;
    endfunction

    function automatic sb_t trapped(input logic cause);
        sb_t s = base(1'b0);
        s.val.trap = 1'b1; s.care.cause = 1'b1; s.val.cause = cause;
        return s;
    endfunction

    task automatic drain(input string tag);
        sb_t  e;
        exp_t got;
        int   cyc = 0;
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            cyc++;
            rst = e.rst; mem_ready = e.rdy; zero = e.z; neg = e.n;
            opcode = e.instr[6:0]; funct3 = e.instr[14:12]; funct7_5 = e.instr[30];
            @(negedge clk);
            got.mem_req = mem_req;   got.rdwr = mem_rdwr;    got.pc_write = pc_write;
            got.ir_write = ir_write; got.adr_src = adr_src;  got.a = alu_src_a;
            got.b = alu_src_b;       got.rs = result_src;    got.regwrite = regwrite;
            got.alu = alu_ctrl;      got.imm = imm_src;      got.retire = retire;
            got.trap = trap;         got.cause = trap_cause;
            checks++;
            if ((got & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs=%h required=%h (mask %h)",
                         tag, cyc, got & e.care, e.val & e.care, e.care);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_add();
        cur_instr = 32'h015A04B3;
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(exec_op(2'b00, ALU_ADD));
        sb_q.push_back(writeback(2'b00));
        drain("add");
    endtask

    task automatic test_reset();
        sb_q.push_back(in_reset(1'b1));
        sb_q.push_back(in_reset(1'b0));
        drain("reset");
    endtask

    task automatic test_back_to_back();
        run_add();
        cur_instr = 32'h40B50533;
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(exec_op(2'b00, ALU_SUB));
        sb_q.push_back(writeback(2'b00));
        drain("sub");
    endtask

    task automatic test_i_type();
        cur_instr = 32'h40315093;
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(exec_op(2'b01, ALU_SRA));
        sb_q.push_back(writeback(2'b00));
        drain("srai");
        cur_instr = 32'h40010093;
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(exec_op(2'b01, ALU_ADD));
        sb_q.push_back(writeback(2'b00));
        drain("addi_bit30");
    endtask

    task automatic test_load();
        cur_instr = 32'h00812703;
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(exec_op(2'b01, ALU_ADD));
        for (int i = 0; i < 3; i++) sb_q.push_back(mem_access(1'b0, 1'b0));
        sb_q.push_back(mem_access(1'b1, 1'b0));
        sb_q.push_back(writeback(2'b01));
        drain("lw");
    endtask

    task automatic test_store();
        cur_instr = 32'h00E12423;
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(exec_op(2'b01, ALU_ADD));
        sb_q.push_back(mem_access(1'b1, 1'b1));
        drain("sw");
        // Three waits in FETCH then three in MEM_WR: the counter must restart per access.
        for (int i = 0; i < 3; i++) sb_q.push_back(fetch(1'b0));
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(exec_op(2'b01, ALU_ADD));
        for (int i = 0; i < 3; i++) sb_q.push_back(mem_access(1'b0, 1'b1));
        sb_q.push_back(mem_access(1'b1, 1'b1));
        drain("sw_wait");
    endtask

    task automatic test_branch();
        cur_instr = 32'h00A5C663;
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(branch(1'b0, 1'b1, 1'b1, 1'b1));
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(branch(1'b1, 1'b0, 1'b0, 1'b1));
        drain("blt");
        cur_instr = 32'h00A58663;
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(branch(1'b1, 1'b0, 1'b1, 1'b1));
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(branch(1'b0, 1'b1, 1'b0, 1'b1));
        drain("beq");
    endtask

    task automatic test_illegal();
        cur_instr = 32'h0000007F;
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        for (int i = 0; i < 20; i++) sb_q.push_back(trapped(TRAP_ILLEGAL));
        sb_q.push_back(in_reset(1'b1));
        drain("illegal_opcode");
        run_add();
        cur_instr = 32'h00A5E663;
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(branch(1'b1, 1'b1, 1'b0, 1'b0));
        sb_q.push_back(trapped(TRAP_ILLEGAL));
        sb_q.push_back(trapped(TRAP_ILLEGAL));
        sb_q.push_back(in_reset(1'b0));
        drain("bltu_illegal");
    endtask

    task automatic test_timeout();
        cur_instr = 32'h015A04B3;
        for (int i = 0; i < 4; i++) sb_q.push_back(fetch(1'b0));
        for (int i = 0; i < 3; i++) sb_q.push_back(trapped(TRAP_MEM_TIMEOUT));
        sb_q.push_back(in_reset(1'b0));
        drain("fetch_timeout");
        for (int i = 0; i < 3; i++) sb_q.push_back(fetch(1'b0));
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(exec_op(2'b00, ALU_ADD));
        sb_q.push_back(writeback(2'b00));
        drain("fetch_ready_at_limit");
        cur_instr = 32'h00E12423;
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(exec_op(2'b01, ALU_ADD));
        for (int i = 0; i < 4; i++) sb_q.push_back(mem_access(1'b0, 1'b1));
        sb_q.push_back(trapped(TRAP_MEM_TIMEOUT));
        sb_q.push_back(trapped(TRAP_MEM_TIMEOUT));
        sb_q.push_back(in_reset(1'b0));
        drain("store_timeout");
    endtask

    task automatic test_reset_mid();
        cur_instr = 32'h00E12423;
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(exec_op(2'b01, ALU_ADD));
        sb_q.push_back(mem_access(1'b0, 1'b1));
        sb_q.push_back(in_reset(1'b1));
        sb_q.push_back(fetch(1'b1));
        sb_q.push_back(decode());
        sb_q.push_back(exec_op(2'b01, ALU_ADD));
        sb_q.push_back(mem_access(1'b1, 1'b1));
        drain("reset_mid_store");
        run_add();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        run_add();
        test_back_to_back();
        test_i_type();
        test_load();
        test_store();
        test_branch();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
